// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings, sequencer FSM states and
// opcode classification helpers used by both the sequencer and the ALU.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_CAPT,
        ST_WB
    } state_t;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // mul/div produce a full-width result that lands in HI/LO, not in Rc
    function automatic logic is_hilo_op(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_decode_chk.sv
// Combinational opcode check: legality of a request and whether its result
// is written to HI/LO instead of the register file.
module alu_op_decode_chk
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             legal,
    output logic             hilo
);

    assign legal = is_alu_op(opcode);
    assign hilo  = is_hilo_op(opcode);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one R-format ALU operation: reads Ra/Rb, drives the ALU, captures Z,
// writes back to Rc or HI/LO. Optional macro: ALU_OP_SEQUENCER_DIVZERO_TRAP_EN.
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [REG_AW-1:0]   ra_idx,
    input  logic [REG_AW-1:0]   rb_idx,
    input  logic [REG_AW-1:0]   rc_idx,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [REG_AW-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OPC_W-1:0]    alu_op,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                hi_we,
    output logic                lo_we,
    output logic [DATA_W-1:0]   hi_wdata,
    output logic [DATA_W-1:0]   lo_wdata
);

    state_t              state_reg, state_next;
    logic [OPC_W-1:0]    op_reg;
    logic [REG_AW-1:0]   ra_reg, rb_reg, rc_reg;
    logic                hilo_reg;
    logic [DATA_W-1:0]   alu_a_reg, alu_b_reg;
    logic [OPC_W-1:0]    alu_op_reg;
    logic [2*DATA_W-1:0] z_reg;
    logic                err_reg;
    logic                start_legal, start_hilo;
    logic                accept;
    logic                wb_trap;

    alu_op_decode_chk u_decode_chk (
        .opcode (opcode),
        .legal  (start_legal),
        .hilo   (start_hilo)
    );

    assign accept = (state_reg == ST_IDLE) && start && start_legal;

`ifdef ALU_OP_SEQUENCER_DIVZERO_TRAP_EN
    logic divz_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            divz_reg <= 1'b0;
        end else if (state_reg == ST_CAPT) begin
            divz_reg <= (op_reg == OP_DIV) && (alu_b_reg == '0);
        end
    end

    assign wb_trap = divz_reg;
`else
    assign wb_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            ra_reg     <= '0;
            rb_reg     <= '0;
            rc_reg     <= '0;
            hilo_reg   <= 1'b0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            z_reg      <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // illegal requests are rejected in IDLE with a one-cycle err
            err_reg   <= (state_reg == ST_IDLE) && start && !start_legal;
            if (accept) begin
                op_reg   <= opcode;
                ra_reg   <= ra_idx;
                rb_reg   <= rb_idx;
                rc_reg   <= rc_idx;
                hilo_reg <= start_hilo;
            end
            case (state_reg)
                ST_RD_B: alu_a_reg <= rf_rdata;
                ST_EXEC: begin
                    alu_b_reg  <= rf_rdata;
                    alu_op_reg <= op_reg;
                end
                ST_CAPT: z_reg <= alu_result;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        rf_raddr   = '0;
        done       = 1'b0;
        rf_we      = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        err        = err_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_RD_A;
            ST_RD_A: begin
                rf_raddr   = ra_reg;
                state_next = ST_RD_B;
            end
            ST_RD_B: begin
                rf_raddr   = rb_reg;
                state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_CAPT;
            ST_CAPT: state_next = ST_WB;
            ST_WB: begin
                done       = 1'b1;
                state_next = ST_IDLE;
                if (wb_trap) begin
                    err = 1'b1;
                end else if (hilo_reg) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                end else begin
                    rf_we = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy     = (state_reg != ST_IDLE);
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_op   = alu_op_reg;
    assign rf_waddr = rc_reg;
    assign rf_wdata = z_reg[DATA_W-1:0];
    assign hi_wdata = z_reg[2*DATA_W-1:DATA_W];
    assign lo_wdata = z_reg[DATA_W-1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a register-file and ALU model;
// honours ALU_OP_SEQUENCER_DIVZERO_TRAP_EN for the div-by-zero vector.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  opcode;
    logic [3:0]  ra_idx, rb_idx, rc_idx;
    logic        busy, done, err;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_result;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .ra_idx     (ra_idx),
        .rb_idx     (rb_idx),
        .rc_idx     (rc_idx),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    // register file model: registered read, seed port has priority
    logic [31:0] rf_mem [16];
    logic        seed_we = 1'b0;
    logic [3:0]  seed_addr = '0;
    logic [31:0] seed_data = '0;

    always @(posedge clk) begin
        if (seed_we) rf_mem[seed_addr] <= seed_data;
        else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        rf_rdata <= rf_mem[rf_raddr];
    end

    // ALU model; div returns {remainder, quotient}, div by zero gives {a, all-ones}
    logic [4:0]  sh;
    logic [31:0] t32;
    always_comb begin
        alu_result = '0;
        sh  = alu_b[4:0];
        t32 = '0;
        case (alu_op)
            5'b00011: alu_result = {32'b0, alu_a + alu_b};
            5'b00100: alu_result = {32'b0, alu_a - alu_b};
            5'b00101: alu_result = {32'b0, alu_a >> sh};
            5'b00110: begin
                t32 = $signed(alu_a) >>> sh;
                alu_result = {32'b0, t32};
            end
            5'b00111: alu_result = {32'b0, alu_a << sh};
            5'b01000: begin
                t32 = (alu_a >> sh) | (alu_a << (6'd32 - {1'b0, sh}));
                alu_result = {32'b0, t32};
            end
            5'b01001: begin
                t32 = (alu_a << sh) | (alu_a >> (6'd32 - {1'b0, sh}));
                alu_result = {32'b0, t32};
            end
            5'b01010: alu_result = {32'b0, alu_a & alu_b};
            5'b01011: alu_result = {32'b0, alu_a | alu_b};
            5'b01111: alu_result = {32'b0, alu_a} * {32'b0, alu_b};
            5'b10000: alu_result = (alu_b == 0) ? {alu_a, 32'hFFFF_FFFF}
                                                : {alu_a % alu_b, alu_a / alu_b};
            5'b10001: alu_result = {32'b0, -alu_a};
            5'b10010: alu_result = {32'b0, ~alu_a};
            default:  alu_result = '0;
        endcase
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic seed(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        seed_we = 1'b1; seed_addr = a; seed_data = d;
        @(negedge clk);
        seed_we = 1'b0;
    endtask

    // kind: 0 = Rc write, 1 = HI/LO write, 2 = div-zero trap
    typedef struct {
        string       name;
        logic [4:0]  opc;
        logic [3:0]  ra, rb, rc;
        int          kind;
        logic [31:0] wd, hi, lo;
    } vec_t;

    vec_t vecs [16];

    task automatic run_vec(input vec_t v);
        int lat, n_rf, n_hl, n_lo, n_err, n_errdone;
        logic [3:0]  cap_addr;
        logic [31:0] cap_wd, cap_hi, cap_lo;
        logic        busy1;
        lat = 0; n_rf = 0; n_hl = 0; n_lo = 0; n_err = 0; n_errdone = 0;
        cap_addr = '0; cap_wd = '0; cap_hi = '0; cap_lo = '0; busy1 = 1'b0;
        @(negedge clk);
        start = 1'b1; opcode = v.opc; ra_idx = v.ra; rb_idx = v.rb; rc_idx = v.rc;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) busy1 = busy;
            if (done && lat == 0) lat = k;
            if (rf_we) begin n_rf++; cap_addr = rf_waddr; cap_wd = rf_wdata; end
            if (hi_we) begin n_hl++; cap_hi = hi_wdata; end
            if (lo_we) begin n_lo++; cap_lo = lo_wdata; end
            if (err) n_err++;
            if (err && done) n_errdone++;
        end
        chk({v.name, " busy"}, 64'(busy1), 64'(1));
        chk({v.name, " latency"}, 64'(lat), 64'(5));
        chk({v.name, " rf_we count"}, 64'(n_rf), 64'(v.kind == 0 ? 1 : 0));
        chk({v.name, " hi_we count"}, 64'(n_hl), 64'(v.kind == 1 ? 1 : 0));
        chk({v.name, " lo_we count"}, 64'(n_lo), 64'(v.kind == 1 ? 1 : 0));
        chk({v.name, " err count"}, 64'(n_err), 64'(v.kind == 2 ? 1 : 0));
        if (v.kind == 0) begin
            chk({v.name, " waddr"}, 64'(cap_addr), 64'(v.rc));
            chk({v.name, " wdata"}, 64'(cap_wd), 64'(v.wd));
        end else if (v.kind == 1) begin
            chk({v.name, " hi"}, 64'(cap_hi), 64'(v.hi));
            chk({v.name, " lo"}, 64'(cap_lo), 64'(v.lo));
        end else begin
            chk({v.name, " err with done"}, 64'(n_errdone), 64'(1));
        end
        $display("op %-8s opc=%b ra=%0d rb=%0d rc=%0d lat=%0d rf_we=%0d hilo=%0d err=%0d",
                 v.name, v.opc, v.ra, v.rb, v.rc, lat, n_rf, n_hl, n_err);
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c, cnt_d;
        vecs[0]  = '{"add",    5'b00011, 4'd2,  4'd3,  4'd4,  0, 32'd12,        32'd0, 32'd0};
        vecs[1]  = '{"sub",    5'b00100, 4'd3,  4'd2,  4'd12, 0, 32'd2,         32'd0, 32'd0};
        vecs[2]  = '{"mul",    5'b01111, 4'd5,  4'd6,  4'd0,  1, 32'd0,         32'h3, 32'h0};
        vecs[3]  = '{"and",    5'b01010, 4'd9,  4'd10, 4'd13, 0, 32'h0,         32'd0, 32'd0};
        vecs[4]  = '{"or",     5'b01011, 4'd9,  4'd10, 4'd13, 0, 32'hFF,        32'd0, 32'd0};
        vecs[5]  = '{"shl",    5'b00111, 4'd9,  4'd11, 4'd14, 0, 32'h780,       32'd0, 32'd0};
        vecs[6]  = '{"shr",    5'b00101, 4'd9,  4'd11, 4'd14, 0, 32'h1E,        32'd0, 32'd0};
        vecs[7]  = '{"shra",   5'b00110, 4'd1,  4'd11, 4'd14, 0, 32'hFFFF_FFFE, 32'd0, 32'd0};
        vecs[8]  = '{"ror",    5'b01000, 4'd10, 4'd11, 4'd14, 0, 32'hE000_0001, 32'd0, 32'd0};
        vecs[9]  = '{"rol",    5'b01001, 4'd1,  4'd11, 4'd14, 0, 32'hFFFF_FF87, 32'd0, 32'd0};
        vecs[10] = '{"neg",    5'b10001, 4'd2,  4'd3,  4'd15, 0, 32'hFFFF_FFFB, 32'd0, 32'd0};
        vecs[11] = '{"not",    5'b10010, 4'd10, 4'd3,  4'd15, 0, 32'hFFFF_FFF0, 32'd0, 32'd0};
        vecs[12] = '{"div",    5'b10000, 4'd6,  4'd11, 4'd0,  1, 32'd0,         32'h0, 32'h1_0000};
`ifdef ALU_OP_SEQUENCER_DIVZERO_TRAP_EN
        vecs[13] = '{"div0",   5'b10000, 4'd7,  4'd8,  4'd0,  2, 32'd0,         32'd0, 32'd0};
`else
        vecs[13] = '{"div0",   5'b10000, 4'd7,  4'd8,  4'd0,  1, 32'd0,         32'd9, 32'hFFFF_FFFF};
`endif
        vecs[14] = '{"add_rca", 5'b00011, 4'd2, 4'd3,  4'd2,  0, 32'd12,        32'd0, 32'd0};
        vecs[15] = '{"add_rcb", 5'b00011, 4'd2, 4'd3,  4'd3,  0, 32'd19,        32'd0, 32'd0};

        rst_n = 1'b0; start = 1'b0; opcode = '0; ra_idx = '0; rb_idx = '0; rc_idx = '0;
        for (int i = 0; i < 16; i++) seed(4'(i), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 0);
        chk("rst done", 64'(done), 0);
        chk("rst err", 64'(err), 0);
        chk("rst we", 64'({rf_we, hi_we, lo_we}), 0);
        chk("rst alu_a/b", {alu_a, alu_b}, 0);
        chk("rst alu_op", 64'(alu_op), 0);
        chk("rst raddr", 64'(rf_raddr), 0);
        chk("rst z", {hi_wdata, lo_wdata}, 0);
        $display("reset busy=%0d done=%0d err=%0d", busy, done, err);
        rst_n = 1'b1;

        seed(4'd1, 32'hFFFF_FFF0); seed(4'd2, 32'd5); seed(4'd3, 32'd7);
        seed(4'd5, 32'h1_0000);    seed(4'd6, 32'h3_0000); seed(4'd7, 32'd9);
        seed(4'd8, 32'd0);         seed(4'd9, 32'hF0);     seed(4'd10, 32'h0F);
        seed(4'd11, 32'd3);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // illegal opcodes: one-cycle err, nothing else moves
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            start = 1'b1; opcode = (j == 0) ? 5'b00000 : 5'b11111;
            ra_idx = 4'd2; rb_idx = 4'd3; rc_idx = 4'd4;
            @(negedge clk);
            start = 1'b0;
            chk("illegal err", 64'(err), 1);
            chk("illegal busy", 64'(busy), 0);
            cnt_a = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (err || busy || done || rf_we || hi_we || lo_we || rf_raddr != 0) cnt_a++;
            end
            chk("illegal quiet", 64'(cnt_a), 0);
            $display("illegal opc=%b quiet_violations=%0d", opcode, cnt_a);
        end

        // start held for 20 cycles: accepts every 6 cycles, extra starts dropped
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        @(negedge clk);
        start = 1'b1; opcode = 5'b00011; ra_idx = 4'd9; rb_idx = 4'd10; rc_idx = 4'd4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) cnt_a++;
            if (!busy) cnt_b++;
            if (rf_we) cnt_c++;
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rf_we) cnt_d++;
        end
        chk("b2b done in window", 64'(cnt_a), 3);
        chk("b2b idle cycles", 64'(cnt_b), 3);
        chk("b2b rf_we in window", 64'(cnt_c), 3);
        chk("b2b rf_we total", 64'(cnt_c + cnt_d), 4);
        chk("b2b result", 64'(rf_mem[4]), 64'(32'hFF));
        $display("b2b done=%0d idle=%0d writes=%0d", cnt_a, cnt_b, cnt_c + cnt_d);

        // reset asserted while a sub sits in CAPT
        @(negedge clk);
        start = 1'b1; opcode = 5'b00100; ra_idx = 4'd3; rb_idx = 4'd2; rc_idx = 4'd15;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("midrst in op", 64'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", 64'(busy), 0);
        chk("midrst we/done/err", 64'({rf_we, hi_we, lo_we, done, err}), 0);
        chk("midrst alu", {alu_a, alu_b}, 0);
        chk("midrst alu_op", 64'(alu_op), 0);
        chk("midrst z", {hi_wdata, lo_wdata}, 0);
        rst_n = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rf_we || hi_we || lo_we || done || busy) cnt_a++;
        end
        chk("midrst no write", 64'(cnt_a), 0);
        chk("midrst rc intact", 64'(rf_mem[15]), 64'(32'hFFFF_FFF0));
        $display("midrst activity_after=%0d", cnt_a);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
